// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB-Lite FIFO read slave.
// Contents: HTRANS encodings, HRESP codes, word offsets of the register map
// (HADDR[3:2]), the slave FSM state type and a helper that flags illegal
// accesses.
package ahb_pkg;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Word index of each register (HADDR[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DATA,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // DATA and STATUS are read-only; the reserved slot rejects everything.
  function automatic logic is_err_access(input logic [1:0] idx, input logic wr);
    return (idx == REG_RSVD) || (wr && (idx != REG_CTRL));
  endfunction

endpackage

// File: rtl/ahb_fifo_rd_regs.sv
// CTRL / STATUS storage for the AHB FIFO read slave.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   ctrl_wr_i           CTRL write strobe (data phase)
//   wdata_i[1:0]        CTRL write data: bit0 BLOCK, bit1 clear stickies
//   underflow_set_i     non-blocking read found the FIFO empty
//   timeout_set_i       blocking read gave up (timeout build only)
//   fifo_empty_i        live FIFO empty flag, reported in STATUS bit0
//   block_o             current BLOCK bit
//   status_o, ctrl_o    read views of STATUS and CTRL
// Optional feature macro: AHB_FIFO_RD_TIMEOUT_EN (timeout sticky present).
module ahb_fifo_rd_regs (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ctrl_wr_i,
  input  logic [1:0]  wdata_i,
  input  logic        underflow_set_i,
  input  logic        timeout_set_i,
  input  logic        fifo_empty_i,
  output logic        block_o,
  output logic [31:0] status_o,
  output logic [31:0] ctrl_o
);

  logic block_q, block_d;
  logic underflow_q, underflow_d;
  logic timeout_sticky;
  logic clr;

  assign clr = ctrl_wr_i & wdata_i[1];

  always_comb begin
    block_d = block_q;
    if (ctrl_wr_i) block_d = wdata_i[0];
    // A set arriving in the clearing cycle must not be lost.
    underflow_d = underflow_set_i | (underflow_q & ~clr);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      block_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      block_q     <= block_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef AHB_FIFO_RD_TIMEOUT_EN
  logic timeout_q, timeout_d;

  assign timeout_d = timeout_set_i | (timeout_q & ~clr);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) timeout_q <= 1'b0;
    else          timeout_q <= timeout_d;
  end

  assign timeout_sticky = timeout_q;
`else
  logic unused_timeout_set;
  assign unused_timeout_set = timeout_set_i;
  assign timeout_sticky     = 1'b0;
`endif

  assign block_o  = block_q;
  assign status_o = {29'b0, timeout_sticky, underflow_q, fifo_empty_i};
  assign ctrl_o   = {31'b0, block_q};

endmodule

// File: rtl/ahb_fifo_rd_slave.sv
// AHB-Lite slave exposing a FIFO consumer port as a read-popping DATA
// register, plus STATUS and CTRL registers.
// Ports: HCLK/HRESETn (clock, async active-low reset), AHB-Lite slave
// inputs HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY/HWDATA, outputs
// HRDATA/HREADYOUT/HRESP, FIFO side fifo_empty/fifo_rd_en/fifo_rd_data.
// Optional feature macro: AHB_FIFO_RD_TIMEOUT_EN (bounded blocking reads).
//
// state | meaning
// IDLE  | no data phase, or zero-wait STATUS/CTRL data phase
// POP   | first DATA-read cycle: pop if data, else underflow or block
// DATA  | popped word on HRDATA, transfer completes
// WAIT  | blocking read stalled on an empty FIFO
// ERR1  | ERROR response, first cycle (HREADYOUT low)
// ERR2  | ERROR response, second cycle (HREADYOUT high)
module ahb_fifo_rd_slave
  import ahb_pkg::*;
#(
  parameter int FIFO_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [7:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic              HREADY,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [FIFO_W-1:0] fifo_rd_data
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q;
  logic        wr_q;
  logic        reg_acc_q;
  logic        accept;
  logic        err_a;
  state_e      start_st;
  logic        underflow_set;
  logic        timeout_hit;
  logic        ctrl_wr;
  logic        block;
  logic [31:0] status_rd, ctrl_rd;

  logic unused_bus;
  assign unused_bus = ^{HSIZE, HADDR[7:4], HADDR[1:0], HWDATA[31:2]};

  assign accept = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign err_a  = is_err_access(HADDR[3:2], HWRITE);

  // Where a newly accepted address phase sends the FSM.
  always_comb begin
    start_st = ST_IDLE;
    if (accept) begin
      if (err_a)                        start_st = ST_ERR1;
      else if (HADDR[3:2] == REG_DATA)  start_st = ST_POP;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      wr_q      <= 1'b0;
      reg_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg_acc_q <= accept & ~err_a & (HADDR[3:2] != REG_DATA);
      if (accept) begin
        idx_q <= HADDR[3:2];
        wr_q  <= HWRITE;
      end
    end
  end

`ifdef AHB_FIFO_RD_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) tmo_q <= 8'd0;
    else          tmo_q <= tmo_d;
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  always_comb begin
    state_d       = state_q;
    underflow_set = 1'b0;
    timeout_hit   = 1'b0;
`ifdef AHB_FIFO_RD_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    case (state_q)
      ST_IDLE: state_d = start_st;
      ST_POP: begin
        if (!fifo_empty) begin
          state_d = ST_DATA;
        end else if (!block) begin
          underflow_set = 1'b1;
          state_d       = start_st;
        end else begin
`ifdef AHB_FIFO_RD_TIMEOUT_EN
          // This cycle is already the first wait state; the counter holds
          // the WAIT cycles still allowed.
          if (TIMEOUT == 1) begin
            timeout_hit = 1'b1;
            state_d     = ST_ERR1;
          end else begin
            tmo_d   = 8'(TIMEOUT - 1);
            state_d = ST_WAIT;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_DATA: state_d = start_st;
      ST_WAIT: begin
        if (!fifo_empty) begin
          state_d = ST_POP;
        end else begin
`ifdef AHB_FIFO_RD_TIMEOUT_EN
          if (tmo_q <= 8'd1) begin
            timeout_hit = 1'b1;
            state_d     = ST_ERR1;
          end else begin
            tmo_d = tmo_q - 8'd1;
          end
`endif
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = start_st;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    HRDATA     = 32'd0;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_acc_q && !wr_q)
          HRDATA = (idx_q == REG_STATUS) ? status_rd : ctrl_rd;
      end
      ST_POP: begin
        fifo_rd_en = ~fifo_empty;
        HREADYOUT  = fifo_empty & ~block;
      end
      ST_DATA: HRDATA = 32'(fifo_rd_data);
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // reg_acc_q only ever points at STATUS or CTRL, and STATUS writes error out.
  assign ctrl_wr = reg_acc_q & wr_q & (idx_q == REG_CTRL);

  ahb_fifo_rd_regs u_regs (
    .clk_i           (HCLK),
    .rst_n_i         (HRESETn),
    .ctrl_wr_i       (ctrl_wr),
    .wdata_i         (HWDATA[1:0]),
    .underflow_set_i (underflow_set),
    .timeout_set_i   (timeout_hit),
    .fifo_empty_i    (fifo_empty),
    .block_o         (block),
    .status_o        (status_rd),
    .ctrl_o          (ctrl_rd)
  );

endmodule

// File: tb/tb_ahb_fifo_rd_slave.sv
module tb_ahb_fifo_rd_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [3:0]  fifo_rd_data = 4'd0;

  int checks = 0;
  int errors = 0;

  // FIFO model: pushes from the stimulus, pops on a sampled fifo_rd_en.
  logic [3:0] fmem [0:15];
  int wp = 0;
  int rp = 0;
  int pop_cnt = 0;

  assign fifo_empty = (wp == rp);
  assign HREADY     = HREADYOUT;

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rp[3:0]];
      rp           <= rp + 1;
      pop_cnt      <= pop_cnt + 1;
    end
  end

  ahb_fifo_rd_slave #(.FIFO_W(4), .TIMEOUT(16)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSEL         (HSEL),
    .HADDR        (HADDR),
    .HTRANS       (HTRANS),
    .HWRITE       (HWRITE),
    .HSIZE        (HSIZE),
    .HREADY       (HREADY),
    .HWDATA       (HWDATA),
    .HRDATA       (HRDATA),
    .HREADYOUT    (HREADYOUT),
    .HRESP        (HRESP),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data)
  );

  task automatic push(input logic [3:0] d);
    fmem[wp[3:0]] = d;
    wp = wp + 1;
  endtask

  // One complete non-pipelined transfer; returns data, response, wait count.
  task automatic bus(input logic [7:0] a, input logic w, input logic [31:0] wd,
                     output logic [31:0] rd, output logic rs, output int waits);
    logic done;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    waits = 0; rd = 32'd0; rs = 1'b0; done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge HCLK);
      if (HREADYOUT) begin
        rd = HRDATA; rs = HRESP; done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL bus_bound: HREADYOUT stayed 0 for %0d cycles, required 1", waits);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rs; int w;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 8'h0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b010; HWDATA = 32'h0;
    repeat (2) @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout: got %b need 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp: got %b need 0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h need 0", HRDATA); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b need 0", fifo_rd_en); end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    bus(8'h04, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_status: got %h need 1", rd); end
    bus(8'h08, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h need 0", rd); end
  endtask

  task automatic test_back_to_back();
    int p0;
    push(4'h5); push(4'hA);
    p0 = pop_cnt;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h00; HWRITE = 1'b0;
    @(posedge HCLK); #1;  // first accepted, second address phase held
    @(negedge HCLK);
    checks++; if (fifo_rd_en !== 1'b1 || HREADYOUT !== 1'b0) begin errors++;
      $display("FAIL b2b_pop1: rd_en %b ready %b need 1 0", fifo_rd_en, HREADYOUT); end
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'h5) begin errors++;
      $display("FAIL b2b_data1: ready %b data %h need 1 5", HREADYOUT, HRDATA); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_pop: got %b need 0", fifo_rd_en); end
    @(posedge HCLK); #1;  // second accepted on the completing edge
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (fifo_rd_en !== 1'b1 || HREADYOUT !== 1'b0) begin errors++;
      $display("FAIL b2b_pop2: rd_en %b ready %b need 1 0", fifo_rd_en, HREADYOUT); end
    @(negedge HCLK);
    checks++; if (HREADYOUT !== 1'b1 || HRDATA !== 32'hA) begin errors++;
      $display("FAIL b2b_data2: ready %b data %h need 1 a", HREADYOUT, HRDATA); end
    checks++; if (pop_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pops: got %0d need 2", pop_cnt - p0); end
  endtask

  task automatic test_underflow();
    logic [31:0] rd; logic rs; int w; int p0;
    p0 = pop_cnt;
    bus(8'h00, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h0 || rs !== 1'b0 || w !== 0) begin errors++;
      $display("FAIL uf_read: data %h resp %b waits %0d need 0 0 0", rd, rs, w); end
    checks++; if (pop_cnt !== p0) begin errors++; $display("FAIL uf_no_pop: got %0d need %0d", pop_cnt, p0); end
    bus(8'h04, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL uf_status: got %h need 3", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic rs; int w; int p0;
    push(4'h9);
    p0 = pop_cnt;
    bus(8'h00, 1'b1, 32'h1, rd, rs, w);
    checks++; if (rs !== 1'b1 || w !== 1) begin errors++;
      $display("FAIL err_wr_data: resp %b waits %0d need 1 1", rs, w); end
    bus(8'h0C, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rs !== 1'b1 || w !== 1 || rd !== 32'h0) begin errors++;
      $display("FAIL err_rsvd: resp %b waits %0d data %h need 1 1 0", rs, w, rd); end
    bus(8'h04, 1'b1, 32'h0, rd, rs, w);
    checks++; if (rs !== 1'b1 || w !== 1) begin errors++;
      $display("FAIL err_wr_status: resp %b waits %0d need 1 1", rs, w); end
    checks++; if (pop_cnt !== p0) begin errors++; $display("FAIL err_no_pop: got %0d need %0d", pop_cnt, p0); end
    bus(8'h04, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL err_status_pre: got %h need 2", rd); end
    bus(8'h08, 1'b1, 32'h2, rd, rs, w);
    checks++; if (rs !== 1'b0 || w !== 0) begin errors++;
      $display("FAIL ctrl_wr: resp %b waits %0d need 0 0", rs, w); end
    bus(8'h04, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_status: got %h need 0", rd); end
    bus(8'h00, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h9 || w !== 1) begin errors++;
      $display("FAIL err_then_read: data %h waits %0d need 9 1", rd, w); end
  endtask

  task automatic test_blocking();
    logic [31:0] rd; logic rs; int w;
    bus(8'h08, 1'b1, 32'h1, rd, rs, w);
    bus(8'h08, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_block: got %h need 1", rd); end
    // FIFO stays empty through the first four data-phase cycles; the slave
    // sees data in the fifth, pops in the sixth and completes in the seventh.
    fork
      bus(8'h00, 1'b0, 32'h0, rd, rs, w);
      begin
        repeat (6) @(posedge HCLK);
        #2 push(4'h7);
      end
    join
    checks++; if (rd !== 32'h7 || rs !== 1'b0 || w !== 6) begin errors++;
      $display("FAIL block_read: data %h resp %b waits %0d need 7 0 6", rd, rs, w); end
    bus(8'h08, 1'b1, 32'h0, rd, rs, w);
  endtask

`ifdef AHB_FIFO_RD_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic rs; int w; int p0;
    bus(8'h08, 1'b1, 32'h1, rd, rs, w);
    p0 = pop_cnt;
    bus(8'h00, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rs !== 1'b1 || w !== 17) begin errors++;
      $display("FAIL tmo_read: resp %b waits %0d need 1 17", rs, w); end
    checks++; if (pop_cnt !== p0) begin errors++; $display("FAIL tmo_no_pop: got %0d need %0d", pop_cnt, p0); end
    bus(8'h04, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL tmo_status: got %h need 5", rd); end
    bus(8'h08, 1'b1, 32'h2, rd, rs, w);
  endtask
`endif

  task automatic test_reset_pop();
    logic [31:0] rd; logic rs; int w; int p0;
    push(4'hB); push(4'hC);
    p0 = pop_cnt;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 8'h00; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rp_in_pop: got %b need 1", fifo_rd_en); end
    #1 HRESETn = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin errors++;
      $display("FAIL rp_outputs: rd_en %b ready %b resp %b data %h need 0 1 0 0", fifo_rd_en, HREADYOUT, HRESP, HRDATA); end
    @(posedge HCLK);
    @(posedge HCLK); #1 HRESETn = 1'b1;
    checks++; if (pop_cnt !== p0) begin errors++; $display("FAIL rp_no_pop: got %0d need %0d", pop_cnt, p0); end
    bus(8'h00, 1'b0, 32'h0, rd, rs, w);
    checks++; if (rd !== 32'hB || w !== 1) begin errors++;
      $display("FAIL rp_next_read: data %h waits %0d need b 1", rd, w); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_underflow();
    test_errors();
    test_blocking();
`ifdef AHB_FIFO_RD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_fifo_rd_slave.md
AHB_FIFO_RD_SLAVE -- requirements
Module: ahb_fifo_rd_slave

Interface
REQ-001 Parameter FIFO_W, default 4, FIFO data width (1..32).
REQ-002 Parameter TIMEOUT, default 16, maximum wait states on a blocking empty read (1..255).
REQ-003 Port HCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 Port HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports HSEL in 1, HADDR in 8, HTRANS in 2, HWRITE in 1, HSIZE in 3, HREADY in 1, HWDATA in 32: AHB-Lite slave inputs.
REQ-006 Ports HRDATA out 32, HREADYOUT out 1, HRESP out 1: AHB-Lite slave outputs.
REQ-007 Port fifo_empty  in  1  consumer-side empty flag of the attached FIFO.
REQ-008 Port fifo_rd_en  out  1  single-cycle pop request to the FIFO.
REQ-009 Port fifo_rd_data  in  FIFO_W  popped data, valid the cycle after fifo_rd_en.

Function
REQ-010 Transfer accepted when HSEL & HREADY & HTRANS[1]; HADDR[3:2] and HWRITE registered for the data phase; IDLE/BUSY give zero-wait OKAY.
REQ-011 Register map: 0x0 DATA (RO, read pops), 0x4 STATUS (RO), 0x8 CTRL (RW); 0xC reserved.
REQ-012 STATUS = {29'b0, timeout_sticky[2], underflow_sticky[1], fifo_empty[0]}.
REQ-013 CTRL bit0 BLOCK (reset 0); writing bit1=1 clears both stickies in the same cycle, read-as-0; HWDATA sampled in data phase.
REQ-014 STATUS/CTRL read and CTRL write: zero wait states, OKAY.
REQ-015 FSM states IDLE, POP, DATA, WAIT, ERR1, ERR2.
REQ-016 DATA read, fifo_empty=0 at data-phase cycle 1: IDLE->POP, fifo_rd_en=1 for exactly one cycle, HREADYOUT=0; POP->DATA: HRDATA={zero-extend, fifo_rd_data}, HREADYOUT=1; total one wait state.
REQ-017 DATA read, empty, BLOCK=0: no pop, HRDATA=0, zero wait, OKAY, underflow_sticky set.
REQ-018 DATA read, empty, BLOCK=1: enter WAIT, HREADYOUT=0; on fifo_empty deasserting, WAIT->POP and continue per REQ-016.
REQ-019 Write to DATA or STATUS, or any access to 0xC: two-cycle ERROR (ERR1: HRESP=1 HREADYOUT=0; ERR2: HRESP=1 HREADYOUT=1); no pop.
REQ-020 fifo_rd_en only asserted in POP; never two pops per transfer; no pop on error.
REQ-021 HRDATA=0 whenever not completing a read; HRESP=0 outside ERR1/ERR2.
REQ-022 New address phase accepted in the cycle HREADYOUT=1 ends a data phase (back-to-back pipelining).
REQ-023 Clearing stickies while underflow occurs in same cycle: set wins.

Reset
REQ-024 On HRESETn=0: FSM IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, fifo_rd_en=0, BLOCK=0, stickies=0, timeout counter=0.
REQ-025 Reset mid-transfer (including POP) abandons it; popped data is discarded, no replay.

Configuration
REQ-026 Macro AHB_FIFO_RD_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT wait states with FIFO still empty, go ERR1/ERR2, set timeout_sticky, no pop.
REQ-027 Macro undefined: WAIT holds indefinitely until fifo_empty=0; timeout_sticky reads 0; TIMEOUT unused.

Structure
REQ-028 Shared package ahb_pkg: HTRANS encodings, HRESP codes, register offsets, FSM state enum.
REQ-029 One sub-module ahb_fifo_rd_regs (CTRL/STATUS storage, sticky logic); FSM and bus pipeline in top.

Verification
REQ-030 FIFO holds 0x5,0xA; two back-to-back DATA reads -> HRDATA 0x5 then 0xA, one wait state each, fifo_rd_en pulsed twice.
REQ-031 Empty, BLOCK=0, DATA read -> HRDATA=0, OKAY, zero wait; STATUS read -> 0x3.
REQ-032 Empty, BLOCK=1, fifo_empty drops after 5 cycles with data 0x7 -> 5+1 wait states, HRDATA=0x7, OKAY.
REQ-033 With AHB_FIFO_RD_TIMEOUT_EN, TIMEOUT=16, empty, BLOCK=1 -> 16 wait states then two-cycle ERROR, STATUS bit2=1, no pop.
REQ-034 Write 0x1 to DATA -> two-cycle ERROR, no pop; CTRL write 0x2 -> STATUS bits[2:1]=0.
REQ-035 HRESETn low during POP -> outputs at reset values immediately, next DATA read returns next FIFO entry.
